// File: rtl/row_buffer_seq_ctrl.sv
// Command sequencer for the skewed Q/S row buffer: gates softmax rows in (LOAD) and
// issues the 2N-1 diagonal reads that stream one operand into the systolic array (FEED).
module row_buffer_seq_ctrl #(
  parameter int MATRIX_SIZE = 3,
  parameter int ADDR_WIDTH  = $clog2((MATRIX_SIZE**2) << 2),
  parameter int CNT_WIDTH   = $clog2(2*MATRIX_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  feed_stall,
  output logic                  buf_wr_en,
  output logic                  buf_qs_sel,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic                  feed_valid,
  output logic                  feed_last,
  output logic                  done,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(MATRIX_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_RD  = CNT_WIDTH'(2*MATRIX_SIZE - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_sel;
  logic                 r_loaded_q;
  logic                 r_loaded_s;
  logic [CNT_WIDTH-1:0] r_row;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic                 r_err;
  logic                 r_rd_vld_p1;
  logic                 r_rd_last_p1;

  logic w_accept;
  logic w_cmd_loaded;
  logic w_cmd_ok;
  logic w_wr;
  logic w_rd;
  logic w_row_last;
  logic w_rd_last;

  // A LOAD is legal only for an unloaded operand, a FEED only for a loaded one.
  assign w_accept     = (r_state == S_IDLE) & cmd_valid;
  assign w_cmd_loaded = cmd_op[0] ? r_loaded_s : r_loaded_q;
  assign w_cmd_ok     = cmd_op[1] ? w_cmd_loaded : ~w_cmd_loaded;
  assign w_wr         = (r_state == S_LOAD) & in_valid;
  assign w_rd         = (r_state == S_FEED) & ~feed_stall;
  assign w_row_last   = w_wr & (r_row == LAST_ROW);
  assign w_rd_last    = w_rd & (r_rd_cnt == LAST_RD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_cmd_ok) begin
          w_next = cmd_op[1] ? S_FEED : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_row_last) begin
          w_next = S_DONE;
        end
      end
      S_FEED: begin
        if (w_rd_last) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (r_state == S_IDLE);
    in_ready    = (r_state == S_LOAD);
    buf_wr_en   = w_wr;
    buf_rd_en   = w_rd;
    buf_rd_addr = ADDR_WIDTH'(r_rd_cnt);
    buf_qs_sel  = (r_state != S_IDLE) & r_sel;
    done        = (r_state == S_DONE);
    err         = r_err;
    feed_valid  = r_rd_vld_p1;
    feed_last   = r_rd_last_p1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel        <= 1'b0;
      r_loaded_q   <= 1'b0;
      r_loaded_s   <= 1'b0;
      r_row        <= '0;
      r_rd_cnt     <= '0;
      r_err        <= 1'b0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_last_p1 <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_cmd_ok;
      if (w_accept && w_cmd_ok) begin
        r_sel <= cmd_op[0];
      end
      if (w_wr) begin
        r_row <= w_row_last ? '0 : r_row + CNT_WIDTH'(1);
      end
      if (w_row_last) begin
        if (r_sel) begin
          r_loaded_s <= 1'b1;
        end else begin
          r_loaded_q <= 1'b1;
        end
      end
      // Stalled cycles leave the read counter alone so no diagonal is skipped or repeated.
      if (w_rd) begin
        r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CNT_WIDTH'(1);
      end
      // Buffer read data arrives one cycle after the read is issued.
      r_rd_vld_p1  <= w_rd;
      r_rd_last_p1 <= w_rd_last;
    end
  end

endmodule

// File: tb/tb_row_buffer_seq_ctrl.sv
// Scoreboard bench for row_buffer_seq_ctrl (N=3): stimulus pushes cycle-stamped expected
// events, a negedge monitor pops and compares every event the DUT presents.
module tb_row_buffer_seq_ctrl;

  localparam int AW = 6;
  localparam int K_ERR = 1, K_WR = 2, K_RD = 3, K_FV = 4, K_DONE = 5;

  typedef struct packed {
    int         cyc;
    logic [3:0] kind;
    logic [7:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic          in_valid = 1'b0;
  logic          feed_stall = 1'b0;
  logic          cmd_ready, in_ready, buf_wr_en, buf_qs_sel, buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic          feed_valid, feed_last, done, err;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t q[$];

  row_buffer_seq_ctrl #(.MATRIX_SIZE(3)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .in_valid(in_valid), .in_ready(in_ready),
    .feed_stall(feed_stall), .buf_wr_en(buf_wr_en), .buf_qs_sel(buf_qs_sel),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .feed_valid(feed_valid),
    .feed_last(feed_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic ex(input int c, input int k, input int d);
    ev_t e;
    e.cyc  = c;
    e.kind = 4'(k);
    e.data = 8'(d);
    q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    chk(name, {17'b0, cmd_ready, in_ready, buf_wr_en, buf_qs_sel, buf_rd_en,
               buf_rd_addr, feed_valid, feed_last, done, err}, 32'h4000);
  endtask

  task automatic check_ev(input int k, input int d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event cycle=%0d actual kind=%0d data=%0h required none", cyc, k, d);
    end else begin
      e = q.pop_front();
      if (e.kind != 4'(k) || e.data != 8'(d) || e.cyc != cyc) begin
        failures++;
        $display("FAIL event actual kind=%0d data=%0h cycle=%0d required kind=%0d data=%0h cycle=%0d",
                 k, d, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (buf_wr_en || buf_rd_en) chk("wr_rd_exclusive", {31'b0, buf_wr_en & buf_rd_en}, 0);
      if (feed_last) chk("last_implies_valid", {31'b0, feed_valid}, 1);
      if (err)        check_ev(K_ERR, 0);
      if (buf_wr_en)  check_ev(K_WR, {7'b0, buf_qs_sel});
      if (buf_rd_en)  check_ev(K_RD, {1'b0, buf_qs_sel, buf_rd_addr});
      if (feed_valid) check_ev(K_FV, {6'b0, done, feed_last});
      if (done)       check_ev(K_DONE, {7'b0, buf_qs_sel});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int f;
    // Reset state, then FEED_Q before any load
    tick(2);
    check_idle("reset_hold");
    reset_n = 1'b1;
    tick(1);
    check_idle("reset_release");
    t = cyc;
    ex(t+1, K_ERR, 0);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick;
    cmd_valid = 1'b0;
    tick(3);

    // LOAD_Q with row gaps 1,0,1,1
    t = cyc;
    ex(t+1, K_WR, 0); ex(t+3, K_WR, 0); ex(t+4, K_WR, 0); ex(t+5, K_DONE, 0);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick;
    cmd_valid = 1'b0; in_valid = 1'b1;
    chk("load_in_ready", {31'b0, in_ready}, 1);
    tick;
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1;
    tick(2);
    in_valid = 1'b0;
    chk("load_done_cmd_ready", {31'b0, cmd_ready}, 0);
    tick;
    t = cyc;
    ex(t+1, K_ERR, 0);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick;
    cmd_valid = 1'b0;
    tick(2);

    // FEED_Q without stall
    t = cyc;
    ex(t+1, K_RD, 0);
    ex(t+2, K_RD, 1); ex(t+2, K_FV, 0);
    ex(t+3, K_RD, 2); ex(t+3, K_FV, 0);
    ex(t+4, K_RD, 3); ex(t+4, K_FV, 0);
    ex(t+5, K_RD, 4); ex(t+5, K_FV, 0);
    ex(t+6, K_FV, 3); ex(t+6, K_DONE, 0);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick;
    cmd_valid = 1'b0;
    tick(6);

    // LOAD_S with FEED_S held on cmd_valid, then FEED_S with two stall cycles after addr 1
    t = cyc;
    f = t + 5;
    ex(t+1, K_WR, 1); ex(t+2, K_WR, 1); ex(t+3, K_WR, 1); ex(t+4, K_DONE, 1);
    ex(f+1, K_RD, 64);
    ex(f+2, K_RD, 65); ex(f+2, K_FV, 0);
    ex(f+3, K_FV, 0);
    ex(f+5, K_RD, 66);
    ex(f+6, K_RD, 67); ex(f+6, K_FV, 0);
    ex(f+7, K_RD, 68); ex(f+7, K_FV, 0);
    ex(f+8, K_FV, 3); ex(f+8, K_DONE, 1);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    tick;
    cmd_op = 2'b11; in_valid = 1'b1;
    chk("load_ignores_cmd", {31'b0, cmd_ready}, 0);
    tick(3);
    in_valid = 1'b0;
    tick;
    chk("idle_after_done", {31'b0, cmd_ready}, 1);
    tick;
    cmd_valid = 1'b0;
    tick(2);
    feed_stall = 1'b1;
    #1;
    chk("stall_no_read", {31'b0, buf_rd_en}, 0);
    chk("stall_addr_hold", {26'b0, buf_rd_addr}, 2);
    chk("stall_qs_sel", {31'b0, buf_qs_sel}, 1);
    tick(2);
    feed_stall = 1'b0;
    tick(4);

    // Reset in the middle of FEED_Q after addr 2
    t = cyc;
    ex(t+1, K_RD, 0);
    ex(t+2, K_RD, 1); ex(t+2, K_FV, 0);
    ex(t+3, K_RD, 2); ex(t+3, K_FV, 0);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick;
    cmd_valid = 1'b0;
    tick(3);
    reset_n = 1'b0;
    #1;
    check_idle("mid_feed_reset");
    tick(2);
    reset_n = 1'b1;
    tick;
    check_idle("post_reset_idle");
    t = cyc;
    ex(t+1, K_ERR, 0);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick;
    cmd_valid = 1'b0;
    tick(2);
    t = cyc;
    ex(t+1, K_ERR, 0);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    tick;
    cmd_valid = 1'b0;
    tick(3);

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
